// File: rtl/counter_pkg.sv
// Shared counter/shifter type definitions.
package counter_pkg;

    // Per-cycle request presented to the up/down/modulo counter.
    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        COUNT_UP   = 2'd1,
        COUNT_DOWN = 2'd2,
        LOAD       = 2'd3
    } COUNT_ACTION;

    // Operation selector used by the companion shifter blocks.
    typedef enum logic [1:0] {
        SHIFT_LEFT   = 2'd0,
        SHIFT_RIGHT  = 2'd1,
        ROTATE_LEFT  = 2'd2,
        ROTATE_RIGHT = 2'd3
    } SHIFT_TYPE;

endpackage

// File: rtl/modulo_step.sv
// Combinational next-value / wrap computation for a modulo (limit+1) counter.
// All arithmetic is carried in word_width+1 bits so sums never truncate.
// Priority: illegal step > zero step > out-of-range recovery > normal step.
// A step of 1 with limit 0 is a legal full-circle step (holds at 0, wraps).
module modulo_step #(
    parameter int word_width = 8,
    parameter int step_width = 4
) (
    input  logic [word_width-1:0] value_i,
    input  logic [step_width-1:0] step_i,
    input  logic [word_width-1:0] limit_i,
    input  logic                  down_i,
    output logic [word_width-1:0] next_o,
    output logic                  wrap_o,
    output logic                  illegal_o
);
    localparam logic [word_width:0] ONE_EXT  = {{word_width{1'b0}}, 1'b1};
    localparam logic [word_width:0] ZERO_EXT = {(word_width+1){1'b0}};

    logic [word_width:0] v_ext_s;
    logic [word_width:0] s_ext_s;
    logic [word_width:0] l_ext_s;
    logic [word_width:0] up_sum_s;
    logic [word_width:0] up_wrap_s;
    logic [word_width:0] dn_diff_s;
    logic [word_width:0] dn_wrap_s;

    assign v_ext_s   = {1'b0, value_i};
    assign s_ext_s   = {{(word_width+1-step_width){1'b0}}, step_i};
    assign l_ext_s   = {1'b0, limit_i};
    assign up_sum_s  = v_ext_s + s_ext_s;
    assign up_wrap_s = up_sum_s - (l_ext_s + ONE_EXT);
    assign dn_diff_s = v_ext_s - s_ext_s;
    assign dn_wrap_s = v_ext_s + l_ext_s + ONE_EXT - s_ext_s;

    // Select the next count value and whether this step wraps around the modulus.
    always_comb begin
        next_o    = value_i;
        wrap_o    = 1'b0;
        illegal_o = 1'b0;
        if ((s_ext_s > l_ext_s) && !((l_ext_s == ZERO_EXT) && (s_ext_s == ONE_EXT))) begin
            illegal_o = 1'b1;
        end else if (s_ext_s == ZERO_EXT) begin
            next_o = value_i;
        end else if (v_ext_s > l_ext_s) begin
            // Limit was lowered under the count: snap to the end we are heading towards.
            wrap_o = 1'b1;
            next_o = down_i ? limit_i : {word_width{1'b0}};
        end else if (!down_i) begin
            if (up_sum_s > l_ext_s) begin
                wrap_o = 1'b1;
                next_o = up_wrap_s[word_width-1:0];
            end else begin
                next_o = up_sum_s[word_width-1:0];
            end
        end else begin
            if (s_ext_s > v_ext_s) begin
                wrap_o = 1'b1;
                next_o = dn_wrap_s[word_width-1:0];
            end else begin
                next_o = dn_diff_s[word_width-1:0];
            end
        end
    end
endmodule

// File: rtl/counter_udm.sv
// Up/down modulo counter with load, wrap and error pulses.
// Optional prescaler compiled in with macro COUNTER_UDM_PRESCALE_EN.
module counter_udm
    import counter_pkg::*;
#(
    parameter int word_width = 8,
    parameter int step_width = 4
`ifdef COUNTER_UDM_PRESCALE_EN
    ,
    parameter int prescale_width = 4
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                action,
    input  logic [step_width-1:0]     step,
    input  logic [word_width-1:0]     limit,
    input  logic [word_width-1:0]     D_IN,
`ifdef COUNTER_UDM_PRESCALE_EN
    input  logic [prescale_width-1:0] prescale,
`endif
    output logic [word_width-1:0]     D_OUT,
    output logic                      will_wrap,
    output logic                      wrapped,
    output logic                      err
);
    COUNT_ACTION           act_s;
    logic [word_width-1:0] count_q;
    logic [word_width-1:0] count_d;
    logic                  wrapped_q;
    logic                  wrapped_d;
    logic                  err_q;
    logic                  err_d;
    logic [word_width-1:0] next_s;
    logic                  wrap_s;
    logic                  illegal_s;
    logic                  count_req_s;
    logic                  tick_s;

    assign act_s       = COUNT_ACTION'(action);
    assign count_req_s = (act_s == COUNT_UP) || (act_s == COUNT_DOWN);

    modulo_step #(
        .word_width(word_width),
        .step_width(step_width)
    ) u_modulo_step (
        .value_i  (count_q),
        .step_i   (step),
        .limit_i  (limit),
        .down_i   (act_s == COUNT_DOWN),
        .next_o   (next_s),
        .wrap_o   (wrap_s),
        .illegal_o(illegal_s)
    );

`ifdef COUNTER_UDM_PRESCALE_EN
    logic [prescale_width-1:0] presc_q;
    logic [prescale_width-1:0] presc_d;

    // A count request only ticks once the prescale counter reaches the programmed value.
    always_comb begin
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (count_req_s) begin
            if (presc_q == prescale) begin
                tick_s  = 1'b1;
                presc_d = {prescale_width{1'b0}};
            end else begin
                presc_d = presc_q + {{(prescale_width-1){1'b0}}, 1'b1};
            end
        end else if (act_s == LOAD) begin
            presc_d = {prescale_width{1'b0}};
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescale counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= {prescale_width{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_s = count_req_s;
`endif

    // Wrap lookahead for the tick happening this cycle.
    assign will_wrap = tick_s && wrap_s;

    // Next-state selection for count value and one-cycle status pulses.
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        err_d     = 1'b0;
        case (act_s)
            HOLD: begin
                count_d = count_q;
            end
            COUNT_UP, COUNT_DOWN: begin
                if (!tick_s) begin
                    count_d = count_q;
                end else if (illegal_s) begin
                    err_d = 1'b1;
                end else begin
                    count_d   = next_s;
                    wrapped_d = wrap_s;
                end
            end
            LOAD: begin
                if (D_IN <= limit) begin
                    count_d = D_IN;
                end else begin
                    count_d = limit;
                    err_d   = 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Output registers with synchronous active-low reset overriding any action.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= {word_width{1'b0}};
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            err_q     <= err_d;
        end
    end

    assign D_OUT   = count_q;
    assign wrapped = wrapped_q;
    assign err     = err_q;
endmodule

// File: tb/tb_counter_udm.sv
// Self-checking bench for counter_udm: directed literal scenarios plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_counter_udm;
    localparam int WW = 8;
    localparam int SW = 4;
    localparam logic [1:0] A_HOLD = 2'd0;
    localparam logic [1:0] A_UP   = 2'd1;
    localparam logic [1:0] A_DOWN = 2'd2;
    localparam logic [1:0] A_LOAD = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    action;
    logic [SW-1:0] step;
    logic [WW-1:0] limit;
    logic [WW-1:0] D_IN;
    logic [WW-1:0] D_OUT;
    logic          will_wrap;
    logic          wrapped;
    logic          err;
`ifdef COUNTER_UDM_PRESCALE_EN
    logic [3:0]    prescale;
`endif

    always #5 clk = ~clk;

    counter_udm #(.word_width(WW), .step_width(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .action   (action),
        .step     (step),
        .limit    (limit),
        .D_IN     (D_IN),
`ifdef COUNTER_UDM_PRESCALE_EN
        .prescale (prescale),
`endif
        .D_OUT    (D_OUT),
        .will_wrap(will_wrap),
        .wrapped  (wrapped),
        .err      (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] cnt;
        logic        wrap;
        logic        err;
    } res_t;

    // Outcome of one cycle, stated directly in modular arithmetic.
    function automatic res_t model_next(input int cnt, input int act, input int stp,
                                        input int lim, input int din, input bit tick);
        res_t r;
        bit   legal;
        r.cnt  = cnt;
        r.wrap = 1'b0;
        r.err  = 1'b0;
        legal  = (stp <= lim) || (lim == 0 && stp == 1);
        if (act == 3) begin
            if (din <= lim) r.cnt = din;
            else begin r.cnt = lim; r.err = 1'b1; end
        end else if ((act == 1 || act == 2) && tick) begin
            if (!legal) r.err = 1'b1;
            else if (stp == 0) r.cnt = cnt;
            else if (cnt > lim) begin
                r.cnt  = (act == 1) ? 0 : lim;
                r.wrap = 1'b1;
            end else if (act == 1) begin
                r.cnt  = (cnt + stp) % (lim + 1);
                r.wrap = (cnt + stp) > lim;
            end else begin
                r.cnt  = (cnt - stp + lim + 1) % (lim + 1);
                r.wrap = stp > cnt;
            end
        end
        return r;
    endfunction

    int   m_count   = 0;
    bit   m_wrapped = 1'b0;
    bit   m_err     = 1'b0;
    int   m_psc     = 0;
    bit   m_valid   = 1'b0;
    bit   m_tick;
    res_t m_res;

    always_comb begin
        m_tick = 1'b1;
`ifdef COUNTER_UDM_PRESCALE_EN
        m_tick = (m_psc == int'(prescale));
`endif
        m_res = model_next(m_count, int'(action), int'(step), int'(limit), int'(D_IN), m_tick);
    end

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            m_count   <= 0;
            m_wrapped <= 1'b0;
            m_err     <= 1'b0;
            m_psc     <= 0;
            m_valid   <= 1'b1;
        end else begin
            m_count   <= int'(m_res.cnt);
            m_wrapped <= m_res.wrap;
            m_err     <= m_res.err;
            if (action == A_LOAD) m_psc <= 0;
            else if (action == A_UP || action == A_DOWN) m_psc <= m_tick ? 0 : ((m_psc + 1) % 16);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("d_out",     32'(D_OUT),     32'(m_count));
            check("wrapped",   32'(wrapped),   32'(m_wrapped));
            check("err",       32'(err),       32'(m_err));
            check("will_wrap", 32'(will_wrap), 32'(m_res.wrap));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [1:0] a, input int s, input int l, input int d);
        action = a;
        step   = SW'(s);
        limit  = WW'(l);
        D_IN   = WW'(d);
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    int lim;
    int exp_psc [6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        reset = 1'b0;
        set_in(A_HOLD, 0, 9, 0);
`ifdef COUNTER_UDM_PRESCALE_EN
        prescale = 4'd0;
`endif
        tick_clk();
        tick_clk();
        check("rst_d_out",   32'(D_OUT),   32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
        check("rst_err",     32'(err),     32'd0);
        reset = 1'b1;

        // Up-wrap: 8 + 3 in 0..9 gives 1.
        set_in(A_LOAD, 0, 9, 8); tick_clk();
        check("load8", 32'(D_OUT), 32'd8);
        set_in(A_UP, 3, 9, 0); #1;
        check("up_will_wrap", 32'(will_wrap), 32'd1);
        tick_clk();
        check("up_wrap_val", 32'(D_OUT),   32'd1);
        check("up_wrapped",  32'(wrapped), 32'd1);

        // Down-wrap: 1 - 3 in 0..9 gives 8, then HOLD clears the pulse.
        set_in(A_DOWN, 3, 9, 0); #1;
        check("dn_will_wrap", 32'(will_wrap), 32'd1);
        tick_clk();
        check("dn_wrap_val", 32'(D_OUT),   32'd8);
        check("dn_wrapped",  32'(wrapped), 32'd1);
        set_in(A_HOLD, 3, 9, 0); tick_clk();
        check("hold_val",     32'(D_OUT),   32'd8);
        check("hold_wrapped", 32'(wrapped), 32'd0);

        // Load above limit saturates with err; legal load is clean.
        set_in(A_LOAD, 0, 9, 12); tick_clk();
        check("load12_val", 32'(D_OUT), 32'd9);
        check("load12_err", 32'(err),   32'd1);
        set_in(A_LOAD, 0, 9, 5); tick_clk();
        check("load5_val", 32'(D_OUT), 32'd5);
        check("load5_err", 32'(err),   32'd0);

        // Illegal step leaves the count and flags err only.
        set_in(A_UP, 10, 9, 0); #1;
        check("ill_will_wrap", 32'(will_wrap), 32'd0);
        tick_clk();
        check("ill_val",     32'(D_OUT),   32'd5);
        check("ill_err",     32'(err),     32'd1);
        check("ill_wrapped", 32'(wrapped), 32'd0);

        // Zero step is a quiet tick.
        set_in(A_UP, 0, 9, 0); tick_clk();
        check("zero_val",     32'(D_OUT),   32'd5);
        check("zero_wrapped", 32'(wrapped), 32'd0);
        check("zero_err",     32'(err),     32'd0);

        // Lowered limit under the count: COUNT_DOWN snaps to limit.
        set_in(A_LOAD, 0, 9, 7); tick_clk();
        set_in(A_DOWN, 1, 3, 0); tick_clk();
        check("lower_val",     32'(D_OUT),   32'd3);
        check("lower_wrapped", 32'(wrapped), 32'd1);
        check("lower_err",     32'(err),     32'd0);

        // Limit zero: step 1 holds at 0 and wraps in both directions.
        set_in(A_LOAD, 0, 0, 0); tick_clk();
        set_in(A_UP, 1, 0, 0); tick_clk();
        check("lim0_up_val",     32'(D_OUT),   32'd0);
        check("lim0_up_wrapped", 32'(wrapped), 32'd1);
        set_in(A_DOWN, 1, 0, 0); tick_clk();
        check("lim0_dn_val",     32'(D_OUT),   32'd0);
        check("lim0_dn_wrapped", 32'(wrapped), 32'd1);

        // Reset in the middle of a count burst; restart from step.
        set_in(A_LOAD, 0, 9, 0); tick_clk();
        set_in(A_UP, 2, 9, 0); tick_clk(); tick_clk();
        check("burst_val", 32'(D_OUT), 32'd4);
        reset = 1'b0; tick_clk();
        check("mid_rst_val",     32'(D_OUT),   32'd0);
        check("mid_rst_wrapped", 32'(wrapped), 32'd0);
        check("mid_rst_err",     32'(err),     32'd0);
        reset = 1'b1; tick_clk();
        check("after_rst_val", 32'(D_OUT), 32'd2);

`ifdef COUNTER_UDM_PRESCALE_EN
        // Prescale 2: counts land on the 3rd and 6th request.
        prescale = 4'd2;
        set_in(A_LOAD, 0, 9, 0); tick_clk();
        for (int i = 0; i < 6; i++) begin
            set_in(A_UP, 1, 9, 0); tick_clk();
            check("presc_val", 32'(D_OUT), 32'(exp_psc[i]));
        end
        prescale = 4'd0;
`endif

        // Randomized traffic checked by the every-cycle compare process.
        lim = 9;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
`ifdef COUNTER_UDM_PRESCALE_EN
            if ($urandom_range(0, 31) == 0) prescale = 4'($urandom_range(0, 3));
`endif
            set_in(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), lim,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 17)));
            tick_clk();
        end
        reset = 1'b1;
        set_in(A_HOLD, 0, 9, 0);
        tick_clk();
        tick_clk();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
